// File: rtl/wbf_pkg.sv
// Shared types and helpers for the write-back / fetch stage (wb_fetch_unit).
// The optional sign-extension feature is selected with WBF_SIGN_EXT_EN.
package wbf_pkg;

   typedef enum logic [1:0] {
      LS_BYTE = 2'd0,
      LS_HALF = 2'd1,
      LS_WORD = 2'd2
   } load_size_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } wbf_state_e;

   // Encoding 3 is treated as a word access.
   function automatic int size_bytes(input logic [1:0] size);
      if (size == LS_BYTE) return 1;
      if (size == LS_HALF) return 2;
      return 4;
   endfunction

   function automatic int beats_for_size(input logic [1:0] size, input int mem_w, input int xlen);
      int nbytes;
      nbytes = size_bytes(size);
      if (nbytes * 8 > xlen) nbytes = xlen / 8;
      if (nbytes * 8 <= mem_w) return 1;
      return (nbytes * 8) / mem_w;
   endfunction

endpackage

// File: rtl/wb_fetch_unit_if.sv
// Bus bundle between wb_fetch_unit (slave side) and its memory, ALU and decode neighbours (master side).
interface wb_fetch_unit_if #(
   parameter int XLEN  = 32,
   parameter int MEM_W = 16
);
   logic             load_start_i;
   logic [1:0]       load_size_i;
   logic             load_signed_i;
   logic [MEM_W-1:0] mem_rdata_i;
   logic             mem_rvalid_i;
   logic [XLEN-1:0]  calc_data_i;
   logic             wb_sel_mem_i;
   logic [XLEN-1:0]  wb_data_o;
   logic             wb_valid_o;
   logic             load_busy_o;
   logic             stall_i;
   logic             instr_adv_i;
   logic             branch_i;
   logic [XLEN-1:0]  branch_pc_i;
   logic [XLEN-1:0]  pc_o;
   logic [XLEN-1:0]  next_pc_o;
   logic [XLEN-1:0]  imem_addr_o;
   logic             imem_re_o;

   modport slave (
      input  load_start_i, load_size_i, load_signed_i, mem_rdata_i, mem_rvalid_i,
      input  calc_data_i, wb_sel_mem_i, stall_i, instr_adv_i, branch_i, branch_pc_i,
      output wb_data_o, wb_valid_o, load_busy_o, pc_o, next_pc_o, imem_addr_o, imem_re_o
   );

   modport master (
      output load_start_i, load_size_i, load_signed_i, mem_rdata_i, mem_rvalid_i,
      output calc_data_i, wb_sel_mem_i, stall_i, instr_adv_i, branch_i, branch_pc_i,
      input  wb_data_o, wb_valid_o, load_busy_o, pc_o, next_pc_o, imem_addr_o, imem_re_o
   );
endinterface

// File: rtl/wbf_load_assembler.sv
// Collects MEM_W-bit read beats into one XLEN-bit load result and extends it to full width.
// WBF_SIGN_EXT_EN enables sign extension of signed byte/half loads.
module wbf_load_assembler
   import wbf_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int MEM_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_start_i,
   input  logic [1:0]       load_size_i,
   input  logic             load_signed_i,
   input  logic [MEM_W-1:0] mem_rdata_i,
   input  logic             mem_rvalid_i,
   output logic             load_busy_o,
   output logic             load_done_o,
   output logic [XLEN-1:0]  load_result_o
);

   localparam int MAX_BEATS = XLEN / MEM_W;
   localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

`ifdef WBF_SIGN_EXT_EN
   localparam bit SIGN_EXT = 1'b1;
`else
   localparam bit SIGN_EXT = 1'b0;
`endif

   wbf_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  asm_q;
   logic [XLEN-1:0]  asm_d;
   logic [1:0]       size_q;
   logic             sgn_q;
   logic [XLEN-1:0]  result_q;
   logic             done_q;
   logic             last_beat;

   // Word loads are never sign-extended; only bytes/halves narrower than XLEN get a fill.
   function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                   input logic [1:0] size,
                                                   input logic sgn);
      int              nbits;
      logic            msb;
      logic            fill;
      logic [XLEN-1:0] res;
      nbits = size_bytes(size) * 8;
      if (nbits > XLEN) nbits = XLEN;
      msb = 1'b0;
      for (int i = 0; i < XLEN; i++) begin
         if (i == nbits - 1) msb = raw[i];
      end
      fill = SIGN_EXT & sgn & ((size == LS_BYTE) | (size == LS_HALF)) & msb;
      for (int i = 0; i < XLEN; i++) begin
         res[i] = (i < nbits) ? raw[i] : fill;
      end
      return res;
   endfunction

   assign last_beat = (cnt_q == CNT_W'(beats_for_size(size_q, MEM_W, XLEN) - 1));

   always_comb begin
      asm_d = asm_q;
      if (state_q == ST_COLLECT && mem_rvalid_i) begin
         for (int b = 0; b < MAX_BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) asm_d[b*MEM_W +: MEM_W] = mem_rdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         asm_q    <= '0;
         size_q   <= LS_WORD;
         sgn_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load_start_i) begin
                  state_q <= ST_COLLECT;
                  cnt_q   <= '0;
                  asm_q   <= '0;
                  size_q  <= load_size_i;
                  sgn_q   <= load_signed_i;
               end
            end
            ST_COLLECT: begin
               if (mem_rvalid_i) begin
                  asm_q <= asm_d;
                  if (last_beat) begin
                     // Result is registered with the last beat so it is usable during DONE.
                     state_q  <= ST_DONE;
                     cnt_q    <= '0;
                     result_q <= extend_load(asm_d, size_q, sgn_q);
                     done_q   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign load_busy_o   = (state_q != ST_IDLE);
   assign load_done_o   = done_q;
   assign load_result_o = result_q;

endmodule

// File: rtl/wb_fetch_unit.sv
// Write-back / fetch stage: load assembly, write-back select and program-counter control.
// Build option WBF_SIGN_EXT_EN enables sign-extended byte/half loads.
module wb_fetch_unit
   import wbf_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              MEM_W       = 16,
   parameter int              INSTR_BYTES = 2,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input logic             clk_i,
   input logic             rst_ni,
   wb_fetch_unit_if.slave  bus
);

   if ((XLEN % MEM_W) != 0 || !(MEM_W == 8 || MEM_W == 16 || MEM_W == 32)) begin : g_bad_mem_w
      $error("wb_fetch_unit: MEM_W must be 8/16/32 and divide XLEN");
   end
   if (INSTR_BYTES < 1 || (INSTR_BYTES & (INSTR_BYTES - 1)) != 0) begin : g_bad_instr_bytes
      $error("wb_fetch_unit: INSTR_BYTES must be a power of two");
   end

   localparam logic [XLEN-1:0] PC_INC     = XLEN'(INSTR_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

   logic            load_busy;
   logic            load_done;
   logic [XLEN-1:0] load_result;
   logic            imem_re;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   wbf_load_assembler #(
      .XLEN  (XLEN),
      .MEM_W (MEM_W)
   ) u_asm (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .load_start_i  (bus.load_start_i),
      .load_size_i   (bus.load_size_i),
      .load_signed_i (bus.load_signed_i),
      .mem_rdata_i   (bus.mem_rdata_i),
      .mem_rvalid_i  (bus.mem_rvalid_i),
      .load_busy_o   (load_busy),
      .load_done_o   (load_done),
      .load_result_o (load_result)
   );

   assign bus.wb_data_o   = bus.wb_sel_mem_i ? load_result : bus.calc_data_i;
   assign bus.wb_valid_o  = ~bus.wb_sel_mem_i | load_done;
   assign bus.load_busy_o = load_busy;

   // Fetch is suppressed while a load is being assembled; a branch still redirects.
   assign imem_re = rst_ni & ~bus.stall_i & ~load_busy;
   assign seq_pc  = (pc_q + PC_INC) & ALIGN_MASK;

   always_comb begin
      pc_d = pc_q;
      if (bus.branch_i) begin
         pc_d = bus.branch_pc_i & ALIGN_MASK;
      end else if (bus.instr_adv_i && imem_re) begin
         pc_d = seq_pc;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pc_q <= RESET_PC;
      else         pc_q <= pc_d;
   end

   assign bus.pc_o        = pc_q;
   assign bus.imem_addr_o = pc_q;
   assign bus.imem_re_o   = imem_re;
   assign bus.next_pc_o   = bus.branch_i ? (bus.branch_pc_i & ALIGN_MASK) : seq_pc;

endmodule

// File: tb/tb_wb_fetch_unit.sv
// Bench for wb_fetch_unit: a 16-bit and an 8-bit memory-bus instance, load results checked from a scoreboard.
module tb_wb_fetch_unit;
   import wbf_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   wb_fetch_unit_if #(.XLEN(32), .MEM_W(16)) b16();
   wb_fetch_unit_if #(.XLEN(32), .MEM_W(8))  b8();

   wb_fetch_unit #(.XLEN(32), .MEM_W(16), .INSTR_BYTES(2), .RESET_PC(32'h0)) dut16 (
      .clk_i (clk), .rst_ni (rst_n), .bus (b16)
   );
   wb_fetch_unit #(.XLEN(32), .MEM_W(8), .INSTR_BYTES(2), .RESET_PC(32'h0)) dut8 (
      .clk_i (clk), .rst_ni (rst_n), .bus (b8)
   );

`ifdef WBF_SIGN_EXT_EN
   localparam bit SX = 1'b1;
`else
   localparam bit SX = 1'b0;
`endif

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] q16[$];
   logic [31:0] q8[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Any completed load must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && b16.wb_sel_mem_i && b16.wb_valid_o) begin
         if (q16.size() == 0) chk("wb16_spurious", 32'd1, 32'd0);
         else                 chk("wb16_data", b16.wb_data_o, q16.pop_front());
      end
      if (rst_n && b8.wb_sel_mem_i && b8.wb_valid_o) begin
         if (q8.size() == 0) chk("wb8_spurious", 32'd1, 32'd0);
         else                chk("wb8_data", b8.wb_data_o, q8.pop_front());
      end
   end

   task automatic load16(input logic [1:0] sz, input logic sg, input logic [15:0] w0,
                         input logic [15:0] w1, input logic hold_start, input logic [31:0] exp);
      int nb;
      nb = (sz == 2'd0 || sz == 2'd1) ? 1 : 2;
      b16.load_start_i  = 1'b1;
      b16.load_size_i   = sz;
      b16.load_signed_i = sg;
      tick;
      b16.load_start_i = hold_start;
      chk("busy16_collect", {31'd0, b16.load_busy_o}, 32'd1);
      chk("imem_re16_busy", {31'd0, b16.imem_re_o}, 32'd0);
      q16.push_back(exp);
      b16.mem_rvalid_i = 1'b1;
      b16.mem_rdata_i  = w0;
      tick;
      if (nb == 2) begin
         b16.mem_rdata_i = w1;
         tick;
      end
      b16.mem_rvalid_i = 1'b0;
      b16.load_start_i = 1'b0;
      chk("wb16_valid_lat", {31'd0, b16.wb_valid_o}, 32'd1);
      tick;
      chk("wb16_valid_drop", {31'd0, b16.wb_valid_o}, 32'd0);
      chk("wb16_hold", b16.wb_data_o, exp);
      chk("busy16_idle", {31'd0, b16.load_busy_o}, 32'd0);
   endtask

   task automatic load8(input logic [1:0] sz, input logic sg, input logic [31:0] beats,
                        input logic [31:0] exp);
      int nb;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      b8.load_start_i  = 1'b1;
      b8.load_size_i   = sz;
      b8.load_signed_i = sg;
      tick;
      b8.load_start_i = 1'b0;
      q8.push_back(exp);
      for (int k = 0; k < nb; k++) begin
         b8.mem_rvalid_i = 1'b1;
         b8.mem_rdata_i  = beats[k*8 +: 8];
         tick;
      end
      b8.mem_rvalid_i = 1'b0;
      chk("wb8_valid_lat", {31'd0, b8.wb_valid_o}, 32'd1);
      tick;
      chk("wb8_valid_drop", {31'd0, b8.wb_valid_o}, 32'd0);
   endtask

   initial begin
      b16.load_start_i = 0; b16.load_size_i = 0; b16.load_signed_i = 0; b16.mem_rdata_i = '0;
      b16.mem_rvalid_i = 0; b16.calc_data_i = '0; b16.wb_sel_mem_i = 1; b16.stall_i = 0;
      b16.instr_adv_i = 0; b16.branch_i = 0; b16.branch_pc_i = '0;
      b8.load_start_i = 0; b8.load_size_i = 0; b8.load_signed_i = 0; b8.mem_rdata_i = '0;
      b8.mem_rvalid_i = 0; b8.calc_data_i = '0; b8.wb_sel_mem_i = 1; b8.stall_i = 0;
      b8.instr_adv_i = 0; b8.branch_i = 0; b8.branch_pc_i = '0;

      // Reset values
      #1 rst_n = 1'b0;
      #11;
      chk("rst_pc", b16.pc_o, 32'h0);
      chk("rst_busy", {31'd0, b16.load_busy_o}, 32'd0);
      chk("rst_imem_re", {31'd0, b16.imem_re_o}, 32'd0);
      chk("rst_wbvalid_mem", {31'd0, b16.wb_valid_o}, 32'd0);
      b16.wb_sel_mem_i = 1'b0;
      #1;
      chk("rst_wbvalid_calc", {31'd0, b16.wb_valid_o}, 32'd1);
      b16.wb_sel_mem_i = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      chk("imem_re_idle", {31'd0, b16.imem_re_o}, 32'd1);

      // rvalid while idle must not start anything
      b16.mem_rvalid_i = 1'b1;
      b16.mem_rdata_i  = 16'h5555;
      tick;
      b16.mem_rvalid_i = 1'b0;
      chk("rvalid_idle_busy", {31'd0, b16.load_busy_o}, 32'd0);

      // Loads on the 16-bit bus
      load16(2'd2, 1'b0, 16'hBEEF, 16'hDEAD, 1'b0, 32'hDEADBEEF);
      load16(2'd2, 1'b0, 16'h1234, 16'hABCD, 1'b1, 32'hABCD1234);
      load16(2'd1, 1'b1, 16'h8001, 16'h0000, 1'b0, SX ? 32'hFFFF8001 : 32'h00008001);
      load16(2'd0, 1'b1, 16'h12F3, 16'h0000, 1'b0, SX ? 32'hFFFFFFF3 : 32'h000000F3);
      load16(2'd0, 1'b0, 16'h12F3, 16'h0000, 1'b0, 32'h000000F3);
      load16(2'd3, 1'b1, 16'h0000, 16'h8000, 1'b0, 32'h80000000);

      // Write-back select
      b16.wb_sel_mem_i = 1'b0;
      b16.calc_data_i  = 32'hA5A50F0F;
      #1;
      chk("wb_calc_data", b16.wb_data_o, 32'hA5A50F0F);
      chk("wb_calc_valid", {31'd0, b16.wb_valid_o}, 32'd1);
      b16.wb_sel_mem_i = 1'b1;
      #1;
      chk("wb_mem_held", b16.wb_data_o, 32'h80000000);

      // Loads on the 8-bit bus
      load8(2'd0, 1'b1, 32'h00000080, SX ? 32'hFFFFFF80 : 32'h00000080);
      load8(2'd2, 1'b0, 32'h44332211, 32'h44332211);
      load8(2'd1, 1'b0, 32'h0000BBAA, 32'h0000BBAA);

      // Sequential fetch and stall
      chk("pc_start", b16.pc_o, 32'h0);
      chk("next_pc_seq", b16.next_pc_o, 32'h2);
      b16.instr_adv_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick;
         chk("pc_seq", b16.pc_o, 32'(i * 2));
      end
      b16.stall_i = 1'b1;
      #1;
      chk("imem_re_stall", {31'd0, b16.imem_re_o}, 32'd0);
      tick;
      chk("pc_stall_hold", b16.pc_o, 32'h6);

      // Branch wins over stall and advance; target aligned
      b16.branch_i    = 1'b1;
      b16.branch_pc_i = 32'h103;
      #1;
      chk("next_pc_branch", b16.next_pc_o, 32'h102);
      tick;
      chk("pc_branch", b16.pc_o, 32'h102);
      b16.branch_i = 1'b0; b16.stall_i = 1'b0; b16.instr_adv_i = 1'b0;

      // PC wrap
      b16.branch_i    = 1'b1;
      b16.branch_pc_i = 32'hFFFFFFFE;
      tick;
      b16.branch_i    = 1'b0;
      b16.instr_adv_i = 1'b1;
      #1;
      chk("next_pc_wrap", b16.next_pc_o, 32'h0);
      tick;
      chk("pc_wrap", b16.pc_o, 32'h0);
      b16.instr_adv_i = 1'b0;

      // Reset in the middle of a two-beat load
      b16.branch_i    = 1'b1;
      b16.branch_pc_i = 32'h40;
      tick;
      b16.branch_i = 1'b0;
      chk("pc_pre_rst", b16.pc_o, 32'h40);
      b16.load_start_i = 1'b1;
      b16.load_size_i  = 2'd2;
      tick;
      b16.load_start_i = 1'b0;
      b16.mem_rvalid_i = 1'b1;
      b16.mem_rdata_i  = 16'h7777;
      tick;
      b16.mem_rvalid_i = 1'b0;
      chk("busy_mid_load", {31'd0, b16.load_busy_o}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", {31'd0, b16.load_busy_o}, 32'd0);
      chk("rst_mid_pc", b16.pc_o, 32'h0);
      chk("rst_mid_wbvalid", {31'd0, b16.wb_valid_o}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick;
      chk("post_rst_busy", {31'd0, b16.load_busy_o}, 32'd0);
      load16(2'd2, 1'b0, 16'hCAFE, 16'hF00D, 1'b0, 32'hF00DCAFE);

      repeat (2) tick;
      chk("sb16_empty", 32'(q16.size()), 32'd0);
      chk("sb8_empty", 32'(q8.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
